cgra_config_loader: RTL

Sequences configuration of the processing-cell array. Accepts a stream of 32-bit configuration words over a valid/ready handshake and assembles them into each cell's 64-bit `config_bits` vector. Holds the whole array in reset while loading and releases it only after the last word is written. Sits between the host/DMA configuration port and the `config_bits` and reset inputs of every processing cell.

---
 rtl/cgra_pkg.sv | 14 +
 rtl/config_word_counter.sv | 38 +++
 rtl/cgra_config_loader.sv | 93 +++++++++
 3 files changed

// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA configuration path: loader states and the
// bus/cell configuration widths used by both the loader and the processing cells.
package cgra_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } loader_state_t;

    localparam int CELL_CONFIG_WIDTH = 64;
    localparam int CFG_BUS_WIDTH     = 32;

endpackage

// File: rtl/config_word_counter.sv
// Clearable, enable-gated word counter with a terminal-count flag.
// Saturates at MAX_COUNT-1 instead of wrapping; clear has priority over enable.
module config_word_counter #(
    parameter int MAX_COUNT = 32,
    localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o    = (count_q == CW'(MAX_COUNT - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Streams 32-bit configuration words into every cell's config vector and keeps
// the cell array in reset until the final word of a load has been written.
module cgra_config_loader
    import cgra_pkg::*;
#(
    parameter int NUM_CELLS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_start,
    input  logic [CFG_BUS_WIDTH-1:0]             cfg_din,
    input  logic                                 cfg_din_v,
    output logic                                 cfg_din_r,
    output logic [NUM_CELLS*CELL_CONFIG_WIDTH-1:0] config_bits,
    output logic                                 cells_rst_n,
    output logic                                 cfg_done,
    output logic                                 busy
);

    localparam int NUM_WORDS = NUM_CELLS * CELL_CONFIG_WIDTH / CFG_BUS_WIDTH;
    localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    loader_state_t state_q, state_d;
    logic busy_q, busy_d;
    logic cellsRstN_q, cellsRstN_d;
    logic cfgDone_q, cfgDone_d;
    logic [NUM_WORDS-1:0][CFG_BUS_WIDTH-1:0] configBits_q;

    logic [CW-1:0] wordCount;
    logic          wordTc;
    logic          wordAccept;

    // A start pulse overrides any handshake in the same cycle, so that word is dropped.
    assign wordAccept = (state_q == LOAD) && cfg_din_v && !cfg_start;

    config_word_counter #(
        .MAX_COUNT (NUM_WORDS)
    ) u_word_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cfg_start),
        .en_i    (wordAccept),
        .count_o (wordCount),
        .tc_o    (wordTc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            busy_q      <= 1'b0;
            cellsRstN_q <= 1'b0;
            cfgDone_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cellsRstN_q <= cellsRstN_d;
            cfgDone_q   <= cfgDone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (cfg_start) state_d = LOAD;
            LOAD:    if (cfg_start) state_d = LOAD;
                     else if (wordAccept && wordTc) state_d = RUN;
            RUN:     if (cfg_start) state_d = LOAD;
            default: state_d = EMPTY;
        endcase
    end

    // Registered outputs are derived from the next state so they change at the same edge.
    always_comb begin
        cfg_din_r   = (state_q == LOAD);
        busy_d      = (state_d == LOAD);
        cellsRstN_d = (state_d == RUN);
        cfgDone_d   = (state_q == LOAD) && (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            configBits_q <= '0;
        end else if (wordAccept) begin
            configBits_q[wordCount] <= cfg_din;
        end
    end

    assign config_bits = configBits_q;
    assign cells_rst_n = cellsRstN_q;
    assign cfg_done    = cfgDone_q;
    assign busy        = busy_q;

endmodule
